// File: rtl/seq_gen_pkg.sv
// Shared definitions for seq_gen: mode encodings, LFSR tap table, Gray helpers.
package seq_gen_pkg;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DN   = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;
  localparam logic [1:0] MODE_LFSR = 2'b11;

  // Maximal-length Fibonacci taps; bit n-1 set for tap n, feedback into LSB.
  function automatic logic [15:0] lfsr_taps(input int w);
    case (w)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h000C;
    endcase
  endfunction

  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [15:0] gray2bin(input logic [15:0] g);
    logic [15:0] b;
    b[15] = g[15];
    for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/seq_gen_next.sv
// Combinational next-value of the sequence for the current y and step mode.
module seq_gen_next
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] gbin;

  always_comb begin
    // Gray: decode, bump in binary, re-encode; upper pad bits are always zero.
    gbin = WIDTH'(gray2bin(16'(y))) + WIDTH'(1);
    nxt  = y;
    case (mode)
      MODE_UP:   nxt = y + WIDTH'(1);
      MODE_DN:   nxt = y - WIDTH'(1);
      MODE_GRAY: nxt = WIDTH'(bin2gray(16'(gbin)));
      MODE_LFSR: nxt = {y[WIDTH-2:0], ^(y & TAPS)};
      default:   nxt = y;
    endcase
  end

endmodule

// File: rtl/seq_gen.sv
// Programmable sequence generator (binary up/down, Gray, LFSR) with terminal-value wrap.
// Define SEQ_GEN_LOCKUP_GUARD_EN to recover the LFSR from the all-zero state.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {1'b1, {(WIDTH-1){1'b0}}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] ip,
  input  logic             wrap_en,
  input  logic [WIDTH-1:0] wrap_val,
  output logic [WIDTH-1:0] y,
  output logic             wrap,
  output logic             lockup
);

`ifdef SEQ_GEN_LOCKUP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic [WIDTH-1:0] start, nxt;
  logic             lock_q, hit, stuck;

  seq_gen_next #(.WIDTH(WIDTH)) u_next (
    .y    (y),
    .mode (mode),
    .nxt  (nxt)
  );

  assign hit   = wrap_en && (y == wrap_val);
  assign stuck = GUARD && (mode == MODE_LFSR) && (y == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y      <= RESET_VAL;
      start  <= RESET_VAL;
      wrap   <= 1'b0;
      lock_q <= 1'b0;
    end else if (load) begin
      y      <= ip;
      start  <= ip;
      wrap   <= 1'b0;
      lock_q <= 1'b0;
    end else if (en) begin
      wrap <= hit;
      // A stuck LFSR is forced out of zero whether it steps or reloads.
      if (stuck) begin
        y      <= {{(WIDTH-1){1'b0}}, 1'b1};
        lock_q <= 1'b1;
      end else if (hit) begin
        y <= start;
      end else begin
        y <= nxt;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  assign lockup = GUARD ? lock_q : 1'b0;

endmodule

// File: tb/tb_seq_gen.sv
// Directed self-checking bench for seq_gen at WIDTH=4.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n, load, en, wrap_en;
  logic [1:0] mode;
  logic [3:0] ip, wrap_val, y;
  logic       wrap, lockup;

  int n_cmp = 0;
  int n_bad = 0;

  seq_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .en       (en),
    .mode     (mode),
    .ip       (ip),
    .wrap_en  (wrap_en),
    .wrap_val (wrap_val),
    .y        (y),
    .wrap     (wrap),
    .lockup   (lockup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] lfsr_exp [15];
  logic [3:0] gray_exp [4];
  logic [3:0] wrp_y    [8];
  logic       wrp_w    [8];

  initial begin
    lfsr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
                 4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    gray_exp = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
    wrp_y    = '{4'b0001, 4'b0010, 4'b0011, 4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0000};
    wrp_w    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b1; load = 1'b0; en = 1'b0; mode = 2'b11;
    ip = 4'h0; wrap_en = 1'b0; wrap_val = 4'h0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_y", 16'(y), 16'h8);
    chk("rst_wrap", 16'(wrap), 16'h0);
    chk("rst_lockup", 16'(lockup), 16'h0);

    // LFSR from reset: full period back to 1000
    en = 1'b1;
    #5 rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("lfsr_%0d", i), 16'(y), 16'(lfsr_exp[i]));
    end

    // Gray up from 0, then binary down
    load = 1'b1; ip = 4'h0; mode = 2'b10;
    tick();
    chk("gray_load", 16'(y), 16'h0);
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("gray_%0d", i), 16'(y), 16'(gray_exp[i]));
    end
    mode = 2'b01;
    tick();
    chk("down_from_gray", 16'(y), 16'h5);

    // Programmable period 0..3
    load = 1'b1; ip = 4'h0; mode = 2'b00; wrap_en = 1'b1; wrap_val = 4'h3;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("wrap_y_%0d", i), 16'(y), 16'(wrp_y[i]));
      chk($sformatf("wrap_p_%0d", i), 16'(wrap), 16'(wrp_w[i]));
    end

    // load beats en; reload returns to the loaded start
    load = 1'b1; ip = 4'hA; wrap_val = 4'hB;
    tick();
    chk("ld_en_y", 16'(y), 16'hA);
    chk("ld_en_wrap", 16'(wrap), 16'h0);
    load = 1'b0;
    tick();
    chk("ld_step_y", 16'(y), 16'hB);
    tick();
    chk("ld_reload_y", 16'(y), 16'hA);
    chk("ld_reload_wrap", 16'(wrap), 16'h1);
    en = 1'b0;
    tick();
    chk("hold_y", 16'(y), 16'hA);
    chk("hold_wrap", 16'(wrap), 16'h0);

    // Modulo boundaries
    wrap_en = 1'b0; load = 1'b1; ip = 4'hF; mode = 2'b00;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    chk("up_wrap", 16'(y), 16'h0);
    mode = 2'b01;
    tick();
    chk("dn_wrap", 16'(y), 16'hF);

    // LFSR all-zero state
    load = 1'b1; ip = 4'h0; mode = 2'b11;
    tick();
    chk("lz_load_lock", 16'(lockup), 16'h0);
    load = 1'b0;
    tick();
`ifdef SEQ_GEN_LOCKUP_GUARD_EN
    chk("lz_y1", 16'(y), 16'h1);
    chk("lz_lock1", 16'(lockup), 16'h1);
    tick();
    chk("lz_y2", 16'(y), 16'h2);
    chk("lz_lock2", 16'(lockup), 16'h1);
`else
    chk("lz_y1", 16'(y), 16'h0);
    chk("lz_lock1", 16'(lockup), 16'h0);
    tick();
    chk("lz_y2", 16'(y), 16'h0);
    chk("lz_lock2", 16'(lockup), 16'h0);
`endif
    load = 1'b1; ip = 4'h5; en = 1'b0;
    tick();
    chk("lz_clear", 16'(lockup), 16'h0);
    chk("lz_clear_y", 16'(y), 16'h5);

    // Async reset between edges right after a wrap pulse
    load = 1'b1; ip = 4'h0; mode = 2'b00; wrap_en = 1'b1; wrap_val = 4'h1; en = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    chk("pre_rst_wrap", 16'(wrap), 16'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_y", 16'(y), 16'h8);
    chk("mid_rst_wrap", 16'(wrap), 16'h0);
    #1 rst_n = 1'b1;
    wrap_en = 1'b0;
    tick();
    chk("post_rst_y", 16'(y), 16'h9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
